// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data memory arbiter: FSM states, port index and
// the zero address constant.
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_SCRUB = 2'd1,
        ST_SERVE = 2'd2
    } state_e;

    typedef logic port_idx_t;

    localparam logic [31:0] ADDR_ZERO = 32'd0;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-pin bundle of the data memory arbiter. The master side
// is the environment (requesters plus memory); the slave side is the arbiter.
interface data_mem_arbiter_if;

    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [31:0] req_addr0;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata0;
    logic [31:0] req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata0;
    logic [31:0] rsp_rdata1;
    logic        scrub_start;
    logic        scrub_busy;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_we, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, scrub_start, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, scrub_busy,
               mem_we, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_lock, req_addr0, req_addr1,
               req_wdata0, req_wdata1, scrub_start, mem_rd,
        output req_ready, rsp_valid, rsp_rdata0, rsp_rdata1, scrub_busy,
               mem_we, mem_a, mem_wd
    );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Stateless 2-way round-robin grant with lock override; the caller owns the
// round-robin pointer and the lock state.
module rr_arb2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  port_idx_t  rr_i,
    input  logic       lock_active_i,
    input  port_idx_t  lock_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
        gnt_o = 2'b00;
        if (lock_active_i) begin
            // The owner keeps the grant even while it has nothing to send.
            gnt_o[lock_owner_i] = 1'b1;
        end else if (valid_i == 2'b11) begin
            gnt_o[rr_i] = 1'b1;
        end else begin
            gnt_o = valid_i;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter with locked sequences and a zero-fill scrubber in front
// of a single-port, combinational-read data memory.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_arbiter_if.slave bus
);

    localparam int unsigned   CW         = $clog2(LOCK_MAX + 1);
    localparam logic [31:0]   LAST_ADDR  = 32'(DEPTH - 1);
    localparam logic [31:0]   DEPTH_W    = 32'(DEPTH);
    localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

    state_e        state_q, state_d;
    logic [31:0]   scrub_addr_q, scrub_addr_d;
    port_idx_t     rr_q, rr_d;
    logic          lock_active_q, lock_active_d;
    port_idx_t     lock_owner_q, lock_owner_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [1:0]    rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata0_q, rsp_rdata0_d;
    logic [31:0]   rsp_rdata1_q, rsp_rdata1_d;

    logic [1:0]    gnt, ready, accept;
    logic          serve_en, any_acc, acc_we, acc_lock, acc_in_range;
    port_idx_t     acc_port;
    logic [31:0]   acc_addr, acc_wdata, acc_rdata;
    logic [CW-1:0] lock_cnt_inc;
    logic          mem_we;
    logic [31:0]   mem_a, mem_wd;

    rr_arb2 u_arb (
        .valid_i       (bus.req_valid),
        .rr_i          (rr_q),
        .lock_active_i (lock_active_q),
        .lock_owner_i  (lock_owner_q),
        .gnt_o         (gnt)
    );

    // A scrub request in SERVE pre-empts any grant in the same cycle.
    assign serve_en     = (state_q == ST_SERVE) && !bus.scrub_start;
    assign ready        = serve_en ? gnt : 2'b00;
    assign accept       = ready & bus.req_valid;
    assign any_acc      = |accept;
    assign acc_port     = accept[1];
    assign acc_addr     = acc_port ? bus.req_addr1  : bus.req_addr0;
    assign acc_wdata    = acc_port ? bus.req_wdata1 : bus.req_wdata0;
    assign acc_we       = bus.req_we[acc_port];
    assign acc_lock     = bus.req_lock[acc_port];
    assign acc_in_range = acc_addr < DEPTH_W;
    assign acc_rdata    = (acc_we || !acc_in_range) ? 32'd0 : bus.mem_rd;
    assign lock_cnt_inc = (lock_active_q ? lock_cnt_q : '0) + CW'(1);

    always_comb begin
        state_d       = state_q;
        scrub_addr_d  = scrub_addr_q;
        rr_d          = rr_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        lock_cnt_d    = lock_cnt_q;
        mem_we        = 1'b0;
        mem_a         = ADDR_ZERO;
        mem_wd        = 32'd0;
        case (state_q)
            ST_BOOT: begin
                state_d      = ST_SCRUB;
                scrub_addr_d = ADDR_ZERO;
            end
            ST_SCRUB: begin
                mem_we       = 1'b1;
                mem_a        = scrub_addr_q;
                scrub_addr_d = scrub_addr_q + 32'd1;
                if (scrub_addr_q == LAST_ADDR) state_d = ST_SERVE;
            end
            ST_SERVE: begin
                if (bus.scrub_start) begin
                    state_d       = ST_SCRUB;
                    scrub_addr_d  = ADDR_ZERO;
                    lock_active_d = 1'b0;
                    lock_cnt_d    = '0;
                end else if (any_acc) begin
                    mem_we = acc_we && acc_in_range;
                    mem_a  = acc_addr;
                    mem_wd = acc_wdata;
                    rr_d   = ~acc_port;
                    // The beat that hits LOCK_MAX still completes, then the lock drops.
                    if (acc_lock && (lock_cnt_inc < LOCK_LIMIT)) begin
                        lock_active_d = 1'b1;
                        lock_owner_d  = acc_port;
                        lock_cnt_d    = lock_cnt_inc;
                    end else begin
                        lock_active_d = 1'b0;
                        lock_cnt_d    = '0;
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        rsp_valid_d  = accept;
        rsp_rdata0_d = accept[0] ? acc_rdata : rsp_rdata0_q;
        rsp_rdata1_d = accept[1] ? acc_rdata : rsp_rdata1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            scrub_addr_q  <= ADDR_ZERO;
            rr_q          <= 1'b0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
            lock_cnt_q    <= '0;
            rsp_valid_q   <= 2'b00;
            rsp_rdata0_q  <= 32'd0;
            rsp_rdata1_q  <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q       <= state_d;
            scrub_addr_q  <= scrub_addr_d;
            rr_q          <= rr_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            lock_cnt_q    <= lock_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata0_q  <= rsp_rdata0_d;
            rsp_rdata1_q  <= rsp_rdata1_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_rdata0 = rsp_rdata0_q;
    assign bus.rsp_rdata1 = rsp_rdata1_q;
    assign bus.scrub_busy = (state_q != ST_SERVE);
    assign bus.mem_we     = mem_we;
    assign bus.mem_a      = mem_a;
    assign bus.mem_wd     = mem_wd;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single-port word-addressed data memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/DMA port. The block runs a round-robin arbiter with optional locked sequences for read-modify-write. It also runs a zero-fill scrub sequencer after reset and on demand. It sits between the requesters and the memory's `WE`/`A`/`WD`/`ReadData` pins; the memory's own reset input is tied inactive.

## Interface
- `DEPTH`, 256: number of memory words; valid addresses are 0..DEPTH-1.
- `LOCK_MAX`, 16: maximum number of consecutive locked beats before the lock is forced to release.

- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, 2: per-port request valid.
- `req_we`, in, 2: per-port write enable; 1 = write, 0 = read.
- `req_lock`, in, 2: per-port request to hold the grant after this beat.
- `req_addr0`, `req_addr1`, in, 32 each: word address.
- `req_wdata0`, `req_wdata1`, in, 32 each: write data.
- `req_ready`, out, 2: per-port request accepted this cycle.
- `rsp_valid`, out, 2: per-port response valid; a one-cycle pulse.
- `rsp_rdata0`, `rsp_rdata1`, out, 32 each: response read data.
- `scrub_start`, in, 1: request a full zero-fill of the memory.
- `scrub_busy`, out, 1: scrub in progress.
- `mem_we`, out, 1: memory write enable.
- `mem_a`, out, 32: memory address.
- `mem_wd`, out, 32: memory write data.
- `mem_rd`, in, 32: memory combinational read data.

## Operation
- FSM states are BOOT, SCRUB and SERVE.
  - Reset enters BOOT. BOOT → SCRUB unconditionally on the next edge.
  - SCRUB writes 0 to address `scrub_addr`, then increments it. After the write to DEPTH-1, SCRUB → SERVE.
  - In SERVE, `scrub_start` = 1 → SCRUB with `scrub_addr` = 0. A scrub that is already running ignores `scrub_start`.
- `scrub_busy` = 1 in BOOT and SCRUB. `req_ready` = 0 whenever the FSM is not in SERVE.
- `scrub_start` has priority over requests: in a cycle where `scrub_start` is high in SERVE, `req_ready` = 0. Entering SCRUB also clears any lock.
- In SERVE, exactly one port is granted per cycle.
  - Candidates are the ports with `req_valid` set.
  - Round-robin pointer `rr`: the port equal to `rr` wins a tie. After an accepted beat, `rr` moves to the other port.
  - The granted port sees `req_ready` = 1 combinationally.
  - The accept drives `mem_we` = `req_we`, `mem_a` = address, `mem_wd` = wdata in the same cycle.
- Lock rules:
  - An accepted beat with `req_lock` = 1 sets `lock_owner` to that port.
  - While locked, only the owner can be granted, even when the owner's `req_valid` is 0.
  - The lock releases on an accepted owner beat with `req_lock` = 0, or when `lock_cnt` reaches LOCK_MAX. On a forced release, that beat completes normally and `rr` moves to the other port.
- Out-of-range addresses (addr ≥ DEPTH):
  - Write: `mem_we` is forced to 0.
  - Read: response data is 0.
  - In both cases the response is still produced.
- Response:
  - `rsp_valid[i]` pulses on the cycle after port i is accepted.
  - `rsp_rdata` holds `mem_rd` captured at the accept edge for reads, and 0 for writes.
  - `rsp_rdata` holds its value until the next response on that port.
  - Responses have no backpressure.

## Timing
- Reset values:
  - FSM = BOOT, `scrub_addr` = 0, `rr` = 0, no lock, `lock_cnt` = 0.
  - `rsp_valid` = 0 and `rsp_rdata*` = 0.
  - `mem_we` = 0 and `mem_a` = 0 throughout BOOT.
- Initial scrub takes 1 + DEPTH cycles after reset release. The first `req_ready` can occur in cycle DEPTH+1.
- Request-to-response latency is 1 cycle. Sustained throughput is 1 access/cycle.
- A read issued on the cycle after a write to the same address returns the new data.
- Reset asserted mid-scrub or mid-lock aborts immediately. Responses pending in that cycle are dropped.

## Structure
- Package `data_mem_arb_pkg`: FSM state enum, the port index type, and the constant `ADDR_ZERO`.
- One sub-module, `rr_arb2`: a 2-way round-robin grant. It takes valid, `rr` and lock inputs and produces a one-hot grant. It holds no pointer state; the parent owns `rr`.

## Test plan
- Reset release, then DEPTH+1 cycles: `mem_we` = 1 with `mem_a` stepping 0..255 and `mem_wd` = 0. `scrub_busy` falls after the last write, then `req_ready` may rise.
- Both ports valid every cycle with `rr` = 0: grants alternate 0,1,0,1. Each `rsp_valid` arrives exactly 1 cycle after its accept.
- Port 0 writes 0xDEADBEEF to address 5, then port 1 reads address 5: `rsp_rdata1` = 0xDEADBEEF on the cycle after the read accept.
- Port 1 holds `req_lock` with port 0 valid throughout: port 1 gets 16 consecutive grants, the lock is forced to release, and port 0 is granted next.
- Write to address 300 and read of address 300: no `mem_we` pulse, `rsp_rdata` = 0, and both `rsp_valid` pulses still occur.
- `scrub_start` and `req_valid` in the same SERVE cycle: `req_ready` = 0, the scrub restarts at address 0, and the lock is cleared.
